// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with one 32-bit word per line.
// Misses stall the pipeline and are serviced over a req/ack backing-memory port.
module dcache_dm #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_BITS  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result_M,
    input  logic [31:0] rs2_rdata_M,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bm_req,
    output logic        bm_we,
    output logic [31:0] bm_addr,
    output logic [31:0] bm_wdata,
    input  logic        bm_ack,
    input  logic [31:0] bm_rdata
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - 2 - INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_REFILL = 2'd2} state_e;

    function automatic logic illegal_access(input logic st, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return off[0];
            3'b010:  return (off != 2'b00);
            3'b100:  return st;
            3'b101:  return st | off[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b010:  return word;
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] mask;
        case (f3)
            3'b000:  mask = 32'h0000_00FF;
            3'b001:  mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (old & ~mask) | ((wd << {off, 3'b000}) & mask);
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] t, input logic [INDEX_BITS-1:0] i);
        logic [ADDR_BITS-1:0] a;
        a = {t, i, 2'b00};
        return 32'(a);
    endfunction

    logic [LINES-1:0]      valid_q, dirty_q;
    logic [TAG_BITS-1:0]   tag_arr [LINES];
    logic [31:0]           data_arr [LINES];
    state_e                state_q, state_d;
    logic                  bm_req_q, bm_req_d, bm_we_q, bm_we_d;
    logic [31:0]           bm_addr_q, bm_addr_d, bm_wdata_q, bm_wdata_d;
    logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;

    logic                  access_s, idle_ok_s, hit_s, store_hit_s, refill_done_s;
    logic [1:0]            off_s;
    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_BITS-1:0]   tag_s;

    assign access_s      = MemRead | MemWrite;
    assign off_s         = alu_result_M[1:0];
    assign idx_s         = alu_result_M[INDEX_BITS+1:2];
    assign tag_s         = alu_result_M[ADDR_BITS-1:INDEX_BITS+2];
    assign misalign      = access_s & illegal_access(MemWrite, funct3, off_s);
    assign hit_s         = valid_q[idx_s] & (tag_arr[idx_s] == tag_s);
    assign idle_ok_s     = (state_q == S_IDLE) & access_s & ~misalign;
    assign store_hit_s   = idle_ok_s & hit_s & MemWrite;
    assign refill_done_s = (state_q == S_REFILL) & bm_ack;
    // WB/REFILL hold the pipeline even if the access has since dropped.
    assign stall         = ~misalign & ((state_q != S_IDLE) | (access_s & ~hit_s));
    assign mem_rdata     = (idle_ok_s & hit_s & ~MemWrite) ? load_extend(data_arr[idx_s], funct3, off_s) : 32'd0;

    assign bm_req   = bm_req_q;
    assign bm_we    = bm_we_q;
    assign bm_addr  = bm_addr_q;
    assign bm_wdata = bm_wdata_q;

    // Next-state and backing-port register decode; the missing line is latched at miss time.
    always_comb begin
        state_d    = state_q;
        bm_req_d   = bm_req_q;
        bm_we_d    = bm_we_q;
        bm_addr_d  = bm_addr_q;
        bm_wdata_d = bm_wdata_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        case (state_q)
            S_IDLE: begin
                if (idle_ok_s && !hit_s) begin
                    miss_idx_d = idx_s;
                    miss_tag_d = tag_s;
                    bm_req_d   = 1'b1;
                    if (valid_q[idx_s] && dirty_q[idx_s]) begin
                        state_d    = S_WB;
                        bm_we_d    = 1'b1;
                        bm_addr_d  = line_addr(tag_arr[idx_s], idx_s);
                        bm_wdata_d = data_arr[idx_s];
                    end else begin
                        state_d    = S_REFILL;
                        bm_we_d    = 1'b0;
                        bm_addr_d  = line_addr(tag_s, idx_s);
                        bm_wdata_d = 32'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (bm_ack) begin
                    state_d    = S_REFILL;
                    bm_we_d    = 1'b0;
                    bm_addr_d  = line_addr(miss_tag_q, miss_idx_q);
                    bm_wdata_d = 32'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_REFILL: begin
                if (bm_ack) begin
                    state_d    = S_IDLE;
                    bm_req_d   = 1'b0;
                    bm_we_d    = 1'b0;
                    bm_addr_d  = 32'd0;
                    bm_wdata_d = 32'd0;
                end else begin
                    state_d = S_REFILL;
                end
            end
            default: begin
                state_d    = S_IDLE;
                bm_req_d   = 1'b0;
                bm_we_d    = 1'b0;
                bm_addr_d  = 32'd0;
                bm_wdata_d = 32'd0;
            end
        endcase
    end

    // FSM, backing-port outputs and line status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bm_req_q   <= 1'b0;
            bm_we_q    <= 1'b0;
            bm_addr_q  <= 32'd0;
            bm_wdata_q <= 32'd0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            bm_req_q   <= bm_req_d;
            bm_we_q    <= bm_we_d;
            bm_addr_q  <= bm_addr_d;
            bm_wdata_q <= bm_wdata_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            if (store_hit_s) begin
                dirty_q[idx_s] <= 1'b1;
            end else if (refill_done_s) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q gates their use.
    always_ff @(posedge clk) begin
        if (store_hit_s) begin
            data_arr[idx_s] <= store_merge(data_arr[idx_s], rs2_rdata_M, funct3, off_s);
        end else if (refill_done_s) begin
            data_arr[miss_idx_q] <= bm_rdata;
            tag_arr[miss_idx_q]  <= miss_tag_q;
        end
    end
endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: a flat architectural memory predicts every access,
// and a randomly delayed backing memory answers write-backs and refills.
module tb_dcache_dm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] alu_result_M = 32'd0, rs2_rdata_M = 32'd0;
    logic [31:0] mem_rdata, bm_addr, bm_wdata;
    logic        stall, misalign, bm_req, bm_we;
    logic        bm_ack = 1'b0;
    logic [31:0] bm_rdata = 32'd0;

    dcache_dm #(.INDEX_BITS(6), .ADDR_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .alu_result_M(alu_result_M), .rs2_rdata_M(rs2_rdata_M), .mem_rdata(mem_rdata),
        .stall(stall), .misalign(misalign), .bm_req(bm_req), .bm_we(bm_we), .bm_addr(bm_addr),
        .bm_wdata(bm_wdata), .bm_ack(bm_ack), .bm_rdata(bm_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic mis; logic ld; logic [31:0] data; } exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bm_t;
    exp_t sb_q[$];
    bm_t  bm_log[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bm_mem  [logic [31:0]];
    int dly_mode = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] bm_rd(input logic [31:0] a);
        return bm_mem.exists(a) ? bm_mem[a] : init_val(a);
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit tb_mis(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        if (st && f3[2]) return 1'b1;
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] load_exp(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        logic [31:0] v = 32'd0;
        logic [31:0] b;
        for (int i = 0; i < sz; i++) begin
            b = (ref_rd((a + i) & ~32'd3) >> (8 * ((a + i) % 4))) & 32'hFF;
            v = v | (b << (8 * i));
        end
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic store_upd(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] wa, w;
        for (int i = 0; i < acc_size(f3); i++) begin
            wa = (a + i) & ~32'd3;
            w  = ref_rd(wa);
            w[8*((a+i)%4) +: 8] = d[8*i +: 8];
            ref_mem[wa] = w;
        end
    endtask

    // Issue one access, predict its result, and return the number of stalled cycles.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int cyc);
        exp_t e;
        e.mis  = tb_mis(wr, f3, a);
        e.ld   = !wr;
        e.data = (!wr && !e.mis) ? load_exp(f3, a) : 32'd0;
        sb_q.push_back(e);
        if (wr && !e.mis) store_upd(f3, a, d);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; funct3 = f3; alu_result_M = a; rs2_rdata_M = d;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            cyc++;
            if (cyc > 200) begin
                n_checks++; n_fail++;
                $display("FAIL stall_timeout: addr 0x%08h still stalled after %0d cycles", a, cyc);
                break;
            end
        end
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // Monitor: each completed access (access present, no stall) is checked against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (MemRead || MemWrite) && !stall) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_empty: unexpected completion at addr 0x%08h", alu_result_M);
                end else begin
                    e = sb_q.pop_front();
                    check("misalign", 32'(misalign), 32'(e.mis));
                    if (e.mis) check("mis_no_req", 32'(bm_req), 32'd0);
                    if (e.ld) check("rdata", mem_rdata, e.data);
                end
            end
        end
    end

    // Backing memory: acknowledges each request after a fixed or random delay.
    initial begin
        bit busy = 1'b0;
        int dly = 0;
        forever begin
            @(negedge clk);
            bm_ack = 1'b0;
            if (!bm_req) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    dly  = (dly_mode >= 0) ? dly_mode : $urandom_range(0, 3);
                end
                if (dly == 0) begin
                    bm_log.push_back('{bm_we, bm_addr, bm_wdata});
                    if (bm_we) bm_mem[bm_addr] = bm_wdata;
                    else       bm_rdata = bm_rd(bm_addr);
                    bm_ack = 1'b1;
                    busy   = 1'b0;
                end else begin
                    dly--;
                end
            end
        end
    end

    initial begin
        int cyc;
        logic [2:0] f3;
        logic [31:0] a;
        int k;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_bm_req", 32'(bm_req), 32'd0);
        check("rst_bm_addr", bm_addr, 32'd0);
        check("rst_bm_wdata", bm_wdata, 32'd0);

        // Clean miss with a 3-cycle responder delay: REFILL lasts 4 cycles, plus the miss cycle.
        bm_mem[32'h100] = 32'hDEAD_BEEF; ref_mem[32'h100] = 32'hDEAD_BEEF;
        dly_mode = 3;
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, cyc);
        check("lat_clean", 32'(cyc), 32'd5);
        check("log_n1", 32'(bm_log.size()), 32'd1);
        if (bm_log.size() > 0) begin
            check("refill_we", 32'(bm_log[0].we), 32'd0);
            check("refill_addr", bm_log[0].addr, 32'h100);
        end
        dly_mode = 0;
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, cyc); check("lat_lb", 32'(cyc), 32'd0);
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, cyc); check("lat_lbu", 32'(cyc), 32'd0);
        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, cyc); check("lat_lh", 32'(cyc), 32'd0);
        issue(1'b1, 1'b0, 3'b101, 32'h100, 32'd0, cyc); check("lat_lhu", 32'(cyc), 32'd0);
        issue(1'b0, 1'b1, 3'b000, 32'h101, 32'h12, cyc); check("lat_sb", 32'(cyc), 32'd0);

        // Conflicting load on the same index: dirty victim written back, then refill.
        bm_log.delete();
        issue(1'b1, 1'b0, 3'b010, 32'h1100, 32'd0, cyc);
        check("lat_dirty", 32'(cyc), 32'd3);
        check("log_n2", 32'(bm_log.size()), 32'd2);
        if (bm_log.size() == 2) begin
            check("wb_we", 32'(bm_log[0].we), 32'd1);
            check("wb_addr", bm_log[0].addr, 32'h100);
            check("wb_data", bm_log[0].wdata, 32'hDEAD_12EF);
            check("rf_addr", bm_log[1].addr, 32'h1100);
        end

        bm_log.delete();
        issue(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, cyc); check("lat_mis_lw", 32'(cyc), 32'd0);
        issue(1'b0, 1'b1, 3'b001, 32'h101, 32'hFFFF, cyc); check("lat_mis_sh", 32'(cyc), 32'd0);
        check("mis_no_traffic", 32'(bm_log.size()), 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h1100, 32'd0, cyc); check("lat_rehit", 32'(cyc), 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, cyc); check("lat_refetch", 32'(cyc), 32'd2);

        // Asynchronous reset in the middle of a refill.
        dly_mode = 20;
        @(posedge clk); #1;
        MemRead = 1'b1; funct3 = 3'b010; alu_result_M = 32'h300;
        repeat (3) @(negedge clk);
        check("pre_rst_req", 32'(bm_req), 32'd1);
        check("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", 32'(bm_req), 32'd0);
        check("rst_addr_clr", bm_addr, 32'd0);
        MemRead = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        ref_mem.delete();
        foreach (bm_mem[key]) ref_mem[key] = bm_mem[key];
        dly_mode = 0;
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, cyc); check("lat_post_rst", 32'(cyc), 32'd2);

        // Both MemRead and MemWrite high behaves as a store (write-allocate).
        issue(1'b1, 1'b1, 3'b010, 32'h200, 32'h55AA_55AA, cyc); check("lat_sw_miss", 32'(cyc), 32'd2);
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, cyc); check("lat_lw_200", 32'(cyc), 32'd0);
        bm_log.delete();
        issue(1'b1, 1'b0, 3'b010, 32'h1200, 32'd0, cyc);
        check("log_n3", 32'(bm_log.size()), 32'd2);
        if (bm_log.size() > 0) begin
            check("wb2_we", 32'(bm_log[0].we), 32'd1);
            check("wb2_addr", bm_log[0].addr, 32'h200);
            check("wb2_data", bm_log[0].wdata, 32'h55AA_55AA);
        end

        // Random traffic over a few tags and indices to force conflicts and evictions.
        dly_mode = -1;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            k = $urandom_range(0, 19);
            case (k % 5)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            if (k >= 18) f3 = 3'b011 + 3'($urandom_range(0, 1) * 3);
            if ($urandom_range(0, 2) != 0) a = a & ~32'(acc_size(f3) - 1);
            k = $urandom_range(0, 9);
            if (k < 5)      issue(1'b1, 1'b0, f3, a, 32'd0, cyc);
            else if (k < 9) issue(1'b0, 1'b1, f3, a, $urandom, cyc);
            else            issue(1'b1, 1'b1, f3, a, $urandom, cyc);
        end
        repeat (4) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
Direct-mapped, write-back, write-allocate data cache for the MEM stage. It replaces the flat single-cycle data array with parametrised depth, byte/halfword/word loads and stores, and sign/zero extension on loads. It raises a pipeline stall on a miss and services misses through a request/acknowledge backing-memory port. Line size is one 32-bit word.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines); range 1..12
ADDR_BITS, 32, byte-address width used for tag compare; tag width = ADDR_BITS-2-INDEX_BITS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
MemRead  input  1  load request from MEM stage
MemWrite  input  1  store request from MEM stage
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_result_M  input  32  byte address; bits above ADDR_BITS ignored
rs2_rdata_M  input  32  store data, right-aligned
mem_rdata  output  32  extended load data, combinational
stall  output  1  hold pipeline; combinational
misalign  output  1  misaligned or illegal-size access this cycle; combinational
bm_req  output  1  backing-memory request
bm_we  output  1  1 = write-back, 0 = refill
bm_addr  output  32  word-aligned backing address
bm_wdata  output  32  write-back data
bm_ack  input  1  single-cycle completion pulse
bm_rdata  input  32  refill data, valid with bm_ack

Behaviour:
- Address split: offset = addr[1:0]; index = addr[INDEX_BITS+1:2]; tag = addr[ADDR_BITS-1:INDEX_BITS+2].
- Per-line state: valid, dirty, tag, data. Valid and dirty are flop vectors. Tag and data are arrays.
- access = MemRead|MemWrite. When both are high, the access is treated as a store.
- misalign = access & (H/HU/SH with addr[0]=1, or W with addr[1:0]!=0, or funct3 not in the legal set; stores allow only 000/001/010).
- When misalign is high: no array update, no FSM transition, stall=0, mem_rdata=0.
- hit = valid[index] & tag match.
- FSM states: IDLE, WB, REFILL.
- IDLE:
  - Load hit: mem_rdata is the selected byte or halfword at offset, sign- or zero-extended per funct3, in the same cycle; stall=0.
  - Store hit: at the clock edge, merge byte/half/word into the line at offset and set dirty; stall=0.
  - Miss: stall=1 in the same cycle. Next state is WB if the victim is valid & dirty, else REFILL.
- WB: bm_req=1, bm_we=1, bm_addr={victim tag, index, 2'b00}, bm_wdata=victim data. Hold stable until bm_ack, then go to REFILL. stall=1.
- REFILL: bm_req=1, bm_we=0, bm_addr={tag, index, 2'b00}. On bm_ack: data<=bm_rdata, tag<=tag, valid<=1, dirty<=0, go to IDLE. stall=1.
- The following IDLE cycle re-evaluates the access as a hit, so a store merges then and a load returns data then. The pipeline must hold address, data and funct3 stable while stall=1.
- bm_req is a decode of state: it falls the cycle after bm_ack. bm_ack outside WB/REFILL is ignored.
- If access drops while in WB/REFILL, the current transaction still completes; the refilled line is installed and the FSM returns to IDLE.
- Latency:
  - Hit: 0 extra cycles.
  - Clean miss: 1 + N cycles of stall, where N = cycles to bm_ack.
  - Dirty miss: 1 + Nwb + Nrf cycles of stall.
- Reset (asynchronous, any state including mid-transaction): state=IDLE; all valid and dirty cleared; bm_req=0, bm_we=0, bm_addr=0, bm_wdata=0. Data and tag arrays are not reset. Outputs mem_rdata/stall/misalign follow their combinational definitions (0 with no access).

Test Plan:
- Reset, then LW 0x100 → stall=1, bm_req=1, bm_we=0, bm_addr=0x100. Ack with 0xDEADBEEF after 3 cycles → next cycle stall=0, mem_rdata=0xDEADBEEF.
- After the line is resident: LB 0x103 → 0xFFFFFFDE; LBU 0x103 → 0x000000DE; LH 0x102 → 0xFFFFDEAD; LHU 0x100 → 0x0000BEEF; all with stall=0.
- SB 0x101 data 0x12 hit → line becomes 0xDEAD12EF with dirty=1. Then LW 0x1100 (same index, INDEX_BITS=6) → WB to 0x100 with data 0xDEAD12EF, then REFILL at 0x1100.
- LW 0x102 and SH 0x101 → misalign=1, stall=0, no bm_req, and the line contents are unchanged.
- Assert rst_n low during REFILL → bm_req=0 immediately. After release, LW 0x100 misses again (valid cleared).
- MemRead=MemWrite=1, SW 0x200 data 0x55AA55AA on a miss → refill, then merge. A following LW 0x200 returns 0x55AA55AA with dirty=1.
